// File: rtl/conv_sequencer.sv
// Sliding-window convolution sequencer: fetches each KxK window from image memory,
// multiply-accumulates against a latched kernel and hands results out over valid/ready.
// Optional macro CONV_SAT_EN: saturate results to 2*DATA_W bits instead of wrapping.
module conv_sequencer #(
    parameter int DATA_W  = 8,
    parameter int K_SIZE  = 3,
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    localparam int ADDR_W = $clog2(IMG_W * IMG_H),
    localparam int ACC_W  = 2 * DATA_W + $clog2(K_SIZE * K_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [DATA_W*K_SIZE*K_SIZE-1:0]   kernel,
    output logic                              mem_rd,
    output logic [ADDR_W-1:0]                 mem_addr,
    input  logic [DATA_W-1:0]                 mem_data,
    output logic [2*DATA_W-1:0]               out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done
);
    localparam int TAPS   = K_SIZE * K_SIZE;
    localparam int OUT_W  = 2 * DATA_W;
    localparam int TAP_W  = $clog2(TAPS + 1);
    localparam int KW     = $clog2(K_SIZE + 1);
    localparam int ROW_W  = $clog2(IMG_H + 1);
    localparam int COL_W  = $clog2(IMG_W + 1);
    localparam int LAST_R = IMG_H - K_SIZE;
    localparam int LAST_C = IMG_W - K_SIZE;

    typedef enum logic [2:0] {IDLE, FETCH, LAST, OUT, DONE} state_t;

    state_t                     state_q;
    logic [DATA_W*TAPS-1:0]     kernel_q;
    logic [ACC_W-1:0]           acc_q;
    logic [TAP_W-1:0]           tap_q, tap_d1_q;
    logic                       rd_d1_q;
    logic [KW-1:0]              kx_q, ky_q;
    logic [ROW_W-1:0]           r_q;
    logic [COL_W-1:0]           c_q;
    logic                       mem_rd_q, out_valid_q, out_last_q, busy_q, done_q;
    logic [ADDR_W-1:0]          mem_addr_q;
    logic [OUT_W-1:0]           out_data_q;

    logic [DATA_W-1:0]          weight [TAPS];
    logic [ACC_W-1:0]           prod, acc_sum;
    logic [OUT_W-1:0]           result;
    logic [KW-1:0]              kx_d, ky_d;
    logic [ROW_W-1:0]           r_d;
    logic [COL_W-1:0]           c_d;
    logic                       last_win;

    for (genvar gi = 0; gi < TAPS; gi++) begin : g_weight
        assign weight[gi] = kernel_q[gi*DATA_W +: DATA_W];
    end

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col,
                                                   input logic [KW-1:0]    ky,
                                                   input logic [KW-1:0]    kx);
        return ADDR_W'((32'(row) + 32'(ky)) * IMG_W + 32'(col) + 32'(kx));
    endfunction

    // Product belongs to the read issued one cycle earlier, so it uses the delayed tap index.
    always_comb begin
        prod    = '0;
        if (rd_d1_q) prod = ACC_W'(mem_data) * ACC_W'(weight[tap_d1_q]);
        acc_sum = acc_q + prod;
`ifdef CONV_SAT_EN
        result  = (acc_sum[ACC_W-1:OUT_W] != '0) ? '1 : acc_sum[OUT_W-1:0];
`else
        result  = acc_sum[OUT_W-1:0];
`endif
    end

    always_comb begin
        kx_d = kx_q + KW'(1);
        ky_d = ky_q;
        if (kx_q == KW'(K_SIZE - 1)) begin
            kx_d = '0;
            ky_d = ky_q + KW'(1);
        end
        c_d = c_q + COL_W'(1);
        r_d = r_q;
        if (c_q == COL_W'(LAST_C)) begin
            c_d = '0;
            r_d = r_q + ROW_W'(1);
        end
        last_win = (r_q == ROW_W'(LAST_R)) && (c_q == COL_W'(LAST_C));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            kernel_q    <= '0;
            acc_q       <= '0;
            tap_q       <= '0;
            tap_d1_q    <= '0;
            rd_d1_q     <= 1'b0;
            kx_q        <= '0;
            ky_q        <= '0;
            r_q         <= '0;
            c_q         <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_d1_q  <= mem_rd_q;
            tap_d1_q <= tap_q;
            if (state_q == FETCH || state_q == LAST) acc_q <= acc_sum;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        kernel_q   <= kernel;
                        acc_q      <= '0;
                        tap_q      <= '0;
                        kx_q       <= '0;
                        ky_q       <= '0;
                        r_q        <= '0;
                        c_q        <= '0;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= FETCH;
                    end
                end
                FETCH: begin
                    if (tap_q == TAP_W'(TAPS - 1)) begin
                        mem_rd_q   <= 1'b0;
                        mem_addr_q <= '0;
                        state_q    <= LAST;
                    end else begin
                        tap_q      <= tap_q + TAP_W'(1);
                        kx_q       <= kx_d;
                        ky_q       <= ky_d;
                        mem_addr_q <= pix_addr(r_q, c_q, ky_d, kx_d);
                    end
                end
                LAST: begin
                    out_data_q  <= result;
                    out_valid_q <= 1'b1;
                    out_last_q  <= last_win;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            r_q        <= r_d;
                            c_q        <= c_d;
                            acc_q      <= '0;
                            tap_q      <= '0;
                            kx_q       <= '0;
                            ky_q       <= '0;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= pix_addr(r_d, c_d, '0, '0);
                            state_q    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning pixel and kernel weight width (unsigned).
REQ-002 SHALL have parameter K_SIZE, default 3, meaning square kernel edge; taps = K_SIZE*K_SIZE.
REQ-003 SHALL have parameters IMG_W and IMG_H, default 8 each, meaning input image width and height in pixels (each >= K_SIZE).
REQ-004 SHALL have derived local ADDR_W = clog2(IMG_W*IMG_H) and ACC_W = 2*DATA_W + clog2(K_SIZE*K_SIZE).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  begin one full-image convolution; sampled in IDLE only.
REQ-008 kernel  input  DATA_W*K_SIZE*K_SIZE  flattened weights; tap t at bits [t*DATA_W +: DATA_W], t = ky*K_SIZE+kx.
REQ-009 mem_rd  output  1  image memory read strobe.
REQ-010 mem_addr  output  ADDR_W  row-major pixel address, valid while mem_rd=1.
REQ-011 mem_data  input  DATA_W  read data, valid exactly one cycle after mem_rd.
REQ-012 out_data  output  2*DATA_W  convolution result.
REQ-013 out_valid  output  1  out_data valid; held until accepted.
REQ-014 out_ready  input  1  consumer accepts when out_valid & out_ready.
REQ-015 out_last  output  1  qualifies final output of the image (with out_valid).
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse after final output accepted.

Function
REQ-018 SHALL compute valid-region convolution: (IMG_W-K_SIZE+1)*(IMG_H-K_SIZE+1) outputs, raster order, row r/col c = top-left of window.
REQ-019 SHALL latch kernel on the cycle start is accepted; kernel changes mid-image SHALL be ignored.
REQ-020 FSM states SHALL be IDLE, FETCH, LAST, OUT, DONE.
REQ-021 IDLE->FETCH on start; accumulator cleared, tap counter=0, r=c=0.
REQ-022 FETCH SHALL last K_SIZE*K_SIZE cycles, asserting mem_rd with mem_addr=(r+ky)*IMG_W+(c+kx) for tap t in cycle t.
REQ-023 Each cycle SHALL add mem_data*kernel[tap t-1] to an ACC_W accumulator for the read issued the previous cycle (no overflow possible).
REQ-024 FETCH->LAST after final tap issued; LAST adds final product, mem_rd=0, then ->OUT.
REQ-025 OUT SHALL assert out_valid with stable out_data/out_last until out_ready; on handshake advance c (wrap to 0, r+1) and go FETCH, or DONE if last window.
REQ-026 DONE SHALL pulse done for one cycle and return to IDLE; minimum per-output latency 11 cycles for K_SIZE=3 with out_ready=1.
REQ-027 start asserted while busy SHALL be ignored; start in same cycle as DONE SHALL not be accepted until IDLE.
REQ-028 mem_rd SHALL be 0 outside FETCH; out_valid SHALL be 0 outside OUT.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, clear accumulator, counters, r, c, latched kernel, and drive mem_rd, mem_addr, out_data, out_valid, out_last, busy, done to 0.
REQ-030 Reset mid-image SHALL abandon the image; no output or done follows until a new start.

Configuration
REQ-031 Macro CONV_SAT_EN defined: out_data SHALL be accumulator saturated to 2^(2*DATA_W)-1 when it exceeds that value.
REQ-032 CONV_SAT_EN undefined: out_data SHALL be the low 2*DATA_W bits of the accumulator (wrap).

Verification
REQ-033 4x4 image all 1, kernel all 1, out_ready=1 -> 4 outputs each 9, out_last on 4th, done one cycle after.
REQ-034 4x4 ramp image pixel=address, kernel center=1 others 0 -> outputs 5,6,9,10 in order.
REQ-035 3x3 image all 255, kernel all 255 -> single output 65535 with CONV_SAT_EN, 60937 without.
REQ-036 Case REQ-033 with out_ready low 5 cycles on 2nd output -> out_data/out_valid stable, no mem_rd, results unchanged.
REQ-037 rst_n low during FETCH of 2nd output, then start -> no stale output; full 4 outputs of 9 produced again.
REQ-038 start pulsed while busy -> ignored; exactly one done and 4 outputs.
